qed_fetch_adapter: RTL and testbench
====================================

Name: qed_fetch_adapter

Overview:
- Parametrised instruction-fetch adapter for QED formal benches. It sits between the QED instruction source (original plus duplicate stream) and the core's instruction-fetch port, replacing the fixed "{NOP, instr} + registered-rd valid" glue.
- It buffers source instructions in a DEPTH-entry FIFO and answers core fetch requests with SLOTS-wide packed words.
- It handles flush/invalidate without losing QED instructions, supports a wait-for-full or NOP-pad packing mode, and back-pressures the source.

Parameters:
- SLOTS, 2, 32-bit instruction slots per fetch word (1..DEPTH).
- DEPTH, 4, FIFO entries of 32 bits each; must be a power of 2 and at least SLOTS.
- NOP, 32'h00000013, padding instruction (addi x0,x0,0).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- src_instr_i  in  32  instruction from QED source
- src_valid_i  in  1  src_instr_i valid this cycle
- src_stall_o  out  1  source must hold; FIFO full
- fill_mode_i  in  1  0 = issue only with SLOTS entries; 1 = issue with at least 1 entry, pad with NOP
- mem_i_rd_i  in  1  core fetch request
- mem_i_flush_i  in  1  core flush
- mem_i_invalidate_i  in  1  core invalidate
- mem_i_pc_i  in  32  fetch PC (captured, unused for data)
- mem_i_accept_o  out  1  request accepted
- mem_i_valid_o  out  1  response valid, one-cycle pulse
- mem_i_error_o  out  1  tied 0
- mem_i_inst_o  out  SLOTS*32  packed response word
- pend_pc_o  out  32  PC of the outstanding request
- issued_cnt_o  out  32  count of real (non-pad) instructions delivered

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: FIFO count=0; rd/wr pointers=0; state=IDLE; mem_i_valid_o=0; mem_i_inst_o=0; pend_pc_o=0; issued_cnt_o=0; src_stall_o=0; mem_i_accept_o=1 in the first cycle after reset.
- Reset mid-operation: reset discards FIFO contents and any pending request.
- FIFO:
  - src_stall_o = (count==DEPTH), decoded from the registered count only.
  - A push occurs when src_valid_i && !src_stall_o.
  - src_valid_i while stalled is ignored; a bench assertion flags it.
  - A pop in the same cycle does not free space for a same-cycle push.
  - Update rule: count_next = count + push - pop. Pointers wrap modulo DEPTH.
- FSM states are IDLE and PEND.
  - IDLE: mem_i_accept_o=1. If mem_i_rd_i=1, capture mem_i_pc_i into pend_pc_o and go to PEND.
  - PEND: mem_i_accept_o=0. Issue condition: count>=SLOTS (mode 0) or count>=1 (mode 1).
  - When the issue condition holds, pop k = min(count, SLOTS) entries and go to IDLE. mem_i_valid_o=1 the next cycle, with the packed word registered.
- Packing:
  - Slot 0 is bits [31:0] and holds the oldest entry; slot i holds the i-th oldest.
  - Slots k..SLOTS-1 are NOP.
  - issued_cnt_o += k, wrapping at 2^32.
- Latency: minimum 2 cycles. mem_i_rd_i at cycle T gives PEND at T+1 and mem_i_valid_o at T+2 when data is available. Otherwise the request holds in PEND indefinitely.
- Back-to-back requests: accept_o is high in the valid cycle, so a new request can be taken there.
- Flush:
  - mem_i_flush_i or mem_i_invalidate_i in PEND cancels the request: state goes to IDLE, no valid, no pop.
  - FIFO contents are retained.
  - Flush in the same cycle as an issue condition: flush wins, no pop, no valid.
  - Flush in IDLE together with mem_i_rd_i: the request is dropped and the state stays IDLE.
- mem_i_inst_o holds its last value when mem_i_valid_o=0.

Test Plan:
1. SLOTS=2, mode 0: push A=0x00100093, then B=0x00200113; rd at T after both pushes -> valid at T+2 with inst={B,A}; issued_cnt=2; count=0.
2. Mode 1, one entry A, rd -> valid with inst={0x00000013,A}; issued_cnt=1.
3. Mode 0, one entry, rd at T -> no valid at T+1..T+5. Push B at T+5 -> valid at T+7 with {B,A}.
4. Fill 4 entries with DEPTH=4 -> src_stall_o=1; a src_valid_i held high is not pushed. The first issue pops 2 -> src_stall_o=0 the next cycle.
5. PEND with count=2, flush in the same cycle -> no valid, count stays 2. A following rd returns those same two instructions.
6. Assert rst while in PEND with 3 entries -> next cycle: count=0, accept=1, valid=0, issued_cnt=0. Repeat with SLOTS=4, DEPTH=8 and check the 128-bit packing order.

Source files
------------

// File: rtl/qed_fetch_adapter.sv
// rtl/qed_fetch_adapter.sv - QED instruction-fetch adapter: source FIFO, packed SLOTS-wide fetch responses
module qed_fetch_adapter #(
    parameter int          SLOTS = 2,
    parameter int          DEPTH = 4,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           src_instr_i,
    input  logic                  src_valid_i,
    output logic                  src_stall_o,
    input  logic                  fill_mode_i,
    input  logic                  mem_i_rd_i,
    input  logic                  mem_i_flush_i,
    input  logic                  mem_i_invalidate_i,
    input  logic [31:0]           mem_i_pc_i,
    output logic                  mem_i_accept_o,
    output logic                  mem_i_valid_o,
    output logic                  mem_i_error_o,
    output logic [SLOTS*32-1:0]   mem_i_inst_o,
    output logic [31:0]           pend_pc_o,
    output logic [31:0]           issued_cnt_o
);

    // Pointer width is kept at least one bit so DEPTH=1 still elaborates;
    // the mask then forces the single-entry pointer to stay at zero.
    localparam int              PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW      = $clog2(DEPTH + 1);
    localparam logic [PW-1:0]   PMASK   = PW'(DEPTH - 1);
    localparam logic [CW-1:0]   SLOTS_C = CW'(SLOTS);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    // FIFO storage and bookkeeping
    logic [31:0]         fifo_mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic [CW-1:0]       count_next;

    // Request FSM and registered outputs
    state_t              state;
    logic                accept_q;
    logic                valid_q;
    logic [SLOTS*32-1:0] inst_q;
    logic [31:0]         pend_pc_q;
    logic [31:0]         issued_q;

    // Per-cycle decode
    logic                push;
    logic                cancel;
    logic                ready;
    logic                issue;
    logic [CW-1:0]       take;
    logic [SLOTS*32-1:0] packed_word;

    // Full is decoded from the registered count only, so a same-cycle pop
    // never opens room for a same-cycle push.
    assign src_stall_o = (count == DEPTH_C);
    assign push        = src_valid_i && !src_stall_o;
    assign cancel      = mem_i_flush_i || mem_i_invalidate_i;

    // Decide how many entries an issue would take and whether it may issue now
    always_comb begin
        take  = (count >= SLOTS_C) ? SLOTS_C : count;
        ready = fill_mode_i ? (count != '0) : (count >= SLOTS_C);
        issue = (state == PEND) && ready && !cancel;
    end

    // Build the response word: oldest entry in slot 0, NOP in unfilled slots
    always_comb begin
        packed_word = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (CW'(i) < take) begin
                packed_word[i*32 +: 32] = fifo_mem[(rd_ptr + PW'(i)) & PMASK];
            end else begin
                packed_word[i*32 +: 32] = NOP;
            end
        end
    end

    // Occupancy update: push and pop are independent, pop size is 'take'
    always_comb begin
        count_next = count + CW'(push);
        if (issue) begin
            count_next = count_next - take;
        end
    end

    // FIFO data array; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= src_instr_i;
        end
    end

    // FIFO pointers and occupancy; reset discards everything buffered
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr + PW'(1)) & PMASK;
            end
            if (issue) begin
                rd_ptr <= (rd_ptr + PW'(take)) & PMASK;
            end
            count <= count_next;
        end
    end

    // Request FSM: accept in IDLE, wait for data in PEND, flush cancels without popping
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            accept_q  <= 1'b1;
            valid_q   <= 1'b0;
            inst_q    <= '0;
            pend_pc_q <= '0;
            issued_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    // A flush alongside a new request drops that request.
                    if (mem_i_rd_i && !cancel) begin
                        pend_pc_q <= mem_i_pc_i;
                        state     <= PEND;
                        accept_q  <= 1'b0;
                    end
                end
                PEND: begin
                    if (cancel) begin
                        state    <= IDLE;
                        accept_q <= 1'b1;
                    end else if (issue) begin
                        state    <= IDLE;
                        accept_q <= 1'b1;
                        valid_q  <= 1'b1;
                        inst_q   <= packed_word;
                        issued_q <= issued_q + 32'(take);
                    end
                end
                default: begin
                    state    <= IDLE;
                    accept_q <= 1'b1;
                end
            endcase
        end
    end

    assign mem_i_accept_o = accept_q;
    assign mem_i_valid_o  = valid_q;
    assign mem_i_error_o  = 1'b0;
    assign mem_i_inst_o   = inst_q;
    assign pend_pc_o      = pend_pc_q;
    assign issued_cnt_o   = issued_q;

endmodule

// File: tb/tb_qed_fetch_adapter.sv
// tb/tb_qed_fetch_adapter.sv - scoreboard bench for qed_fetch_adapter (2x4 and 4x8 instances)
module tb_qed_fetch_adapter;

    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance a: SLOTS=2, DEPTH=4
    logic        a_rst = 1'b1;
    logic [31:0] a_src_instr = '0;
    logic        a_src_valid = 1'b0;
    logic        a_stall;
    logic        a_mode = 1'b0;
    logic        a_rd = 1'b0;
    logic        a_flush = 1'b0;
    logic        a_inval = 1'b0;
    logic [31:0] a_pc = '0;
    logic        a_accept;
    logic        a_valid;
    logic        a_error;
    logic [63:0] a_inst;
    logic [31:0] a_pend_pc;
    logic [31:0] a_issued;

    // Instance b: SLOTS=4, DEPTH=8
    logic         b_rst = 1'b1;
    logic [31:0]  b_src_instr = '0;
    logic         b_src_valid = 1'b0;
    logic         b_stall;
    logic         b_mode = 1'b0;
    logic         b_rd = 1'b0;
    logic         b_flush = 1'b0;
    logic         b_inval = 1'b0;
    logic [31:0]  b_pc = '0;
    logic         b_accept;
    logic         b_valid;
    logic         b_error;
    logic [127:0] b_inst;
    logic [31:0]  b_pend_pc;
    logic [31:0]  b_issued;

    qed_fetch_adapter #(.SLOTS(2), .DEPTH(4), .NOP(NOP)) dut_a (
        .clk(clk), .rst(a_rst),
        .src_instr_i(a_src_instr), .src_valid_i(a_src_valid), .src_stall_o(a_stall),
        .fill_mode_i(a_mode), .mem_i_rd_i(a_rd), .mem_i_flush_i(a_flush),
        .mem_i_invalidate_i(a_inval), .mem_i_pc_i(a_pc),
        .mem_i_accept_o(a_accept), .mem_i_valid_o(a_valid), .mem_i_error_o(a_error),
        .mem_i_inst_o(a_inst), .pend_pc_o(a_pend_pc), .issued_cnt_o(a_issued)
    );

    qed_fetch_adapter #(.SLOTS(4), .DEPTH(8), .NOP(NOP)) dut_b (
        .clk(clk), .rst(b_rst),
        .src_instr_i(b_src_instr), .src_valid_i(b_src_valid), .src_stall_o(b_stall),
        .fill_mode_i(b_mode), .mem_i_rd_i(b_rd), .mem_i_flush_i(b_flush),
        .mem_i_invalidate_i(b_inval), .mem_i_pc_i(b_pc),
        .mem_i_accept_o(b_accept), .mem_i_valid_o(b_valid), .mem_i_error_o(b_error),
        .mem_i_inst_o(b_inst), .pend_pc_o(b_pend_pc), .issued_cnt_o(b_issued)
    );

    typedef struct {
        logic [127:0] inst;
        logic [31:0]  cnt;
        int           at;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   errors = 0;
    int   checks = 0;
    int   a_ignored = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pushes attempted while the FIFO is full are flagged and counted
    always @(negedge clk) begin
        if (!a_rst && a_src_valid && a_stall) a_ignored++;
    end

    // Monitor a: every response must match the oldest expectation
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (a_valid) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_valid: got inst %h at cycle %0d, expected no response", a_inst, cyc);
            end else begin
                e = qa.pop_front();
                if ({64'b0, a_inst} !== e.inst || a_issued !== e.cnt || (e.at >= 0 && cyc != e.at)) begin
                    errors++;
                    $display("FAIL a_response: got inst %h cnt %0d cycle %0d, expected inst %h cnt %0d cycle %0d",
                             a_inst, a_issued, cyc, e.inst[63:0], e.cnt, e.at);
                end
            end
        end
    end

    // Monitor b
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (b_valid) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_valid: got inst %h at cycle %0d, expected no response", b_inst, cyc);
            end else begin
                e = qb.pop_front();
                if (b_inst !== e.inst || b_issued !== e.cnt || (e.at >= 0 && cyc != e.at)) begin
                    errors++;
                    $display("FAIL b_response: got inst %h cnt %0d cycle %0d, expected inst %h cnt %0d cycle %0d",
                             b_inst, b_issued, cyc, e.inst, e.cnt, e.at);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_a(input logic [127:0] inst, input logic [31:0] cnt, input int at);
        exp_t e;
        e.inst = inst; e.cnt = cnt; e.at = at;
        qa.push_back(e);
    endtask

    task automatic expect_b(input logic [127:0] inst, input logic [31:0] cnt, input int at);
        exp_t e;
        e.inst = inst; e.cnt = cnt; e.at = at;
        qb.push_back(e);
    endtask

    task automatic a_reset(input string tag);
        a_rst = 1'b1; a_rd = 1'b0; a_src_valid = 1'b0; a_flush = 1'b0; a_inval = 1'b0;
        step(1);
        a_rst = 1'b0;
        check({tag, "_valid"},  {127'b0, a_valid},  128'd0);
        check({tag, "_accept"}, {127'b0, a_accept}, 128'd1);
        check({tag, "_stall"},  {127'b0, a_stall},  128'd0);
        check({tag, "_issued"}, {96'b0, a_issued},  128'd0);
    endtask

    task automatic b_reset(input string tag);
        b_rst = 1'b1; b_rd = 1'b0; b_src_valid = 1'b0; b_flush = 1'b0; b_inval = 1'b0;
        step(1);
        b_rst = 1'b0;
        check({tag, "_valid"},  {127'b0, b_valid},  128'd0);
        check({tag, "_accept"}, {127'b0, b_accept}, 128'd1);
        check({tag, "_issued"}, {96'b0, b_issued},  128'd0);
    endtask

    task automatic a_push(input logic [31:0] w);
        a_src_instr = w; a_src_valid = 1'b1;
        step(1);
        a_src_valid = 1'b0;
    endtask

    task automatic b_push(input logic [31:0] w);
        b_src_instr = w; b_src_valid = 1'b1;
        step(1);
        b_src_valid = 1'b0;
    endtask

    task automatic a_req(input logic [31:0] pc);
        a_pc = pc; a_rd = 1'b1;
        step(1);
        a_rd = 1'b0;
    endtask

    task automatic b_req(input logic [31:0] pc);
        b_pc = pc; b_rd = 1'b1;
        step(1);
        b_rd = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d/%0d responses outstanding, expected 0", name, qa.size(), qb.size());
            qa.delete();
            qb.delete();
        end
    endtask

    localparam logic [31:0] IA = 32'h00100093;
    localparam logic [31:0] IB = 32'h00200113;

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] c [4];
        c[0] = 32'h11111111; c[1] = 32'h22222222; c[2] = 32'h33333333; c[3] = 32'h44444444;
        step(1);

        // 1: mode 0, two entries, 2-cycle latency, {B,A}
        a_reset("t1_rst");
        a_mode = 1'b0;
        a_push(IA);
        a_push(IB);
        expect_a({64'b0, IB, IA}, 32'd2, cyc + 2);
        a_req(32'h0000_0100);
        check("t1_accept_pend", {127'b0, a_accept}, 128'd0);
        check("t1_pend_pc", {96'b0, a_pend_pc}, 128'h100);
        check("t1_error", {127'b0, a_error}, 128'd0);
        drain("t1", 6);

        // 2: mode 1, one entry padded with NOP
        a_reset("t2_rst");
        a_mode = 1'b1;
        a_push(IA);
        expect_a({64'b0, NOP, IA}, 32'd1, cyc + 2);
        a_req(32'h0000_0200);
        drain("t2", 6);

        // 3: mode 0 with one entry waits; second entry at T+5 completes at T+7
        a_reset("t3_rst");
        a_mode = 1'b0;
        a_push(IA);
        a_req(32'h0000_0300);
        step(4);
        check("t3_still_pend", {127'b0, a_accept}, 128'd0);
        expect_a({64'b0, IB, IA}, 32'd2, cyc + 2);
        a_push(IB);
        drain("t3", 8);

        // 4: fill to DEPTH, held source is not pushed, issue frees space next cycle
        a_reset("t4_rst");
        a_mode = 1'b0;
        a_src_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_src_instr = c[i];
            step(1);
        end
        check("t4_stall_full", {127'b0, a_stall}, 128'd1);
        a_src_instr = 32'hdeadbeef;
        step(2);
        a_src_valid = 1'b0;
        check("t4_ignored_pushes", 128'(a_ignored), 128'd2);
        expect_a({64'b0, c[1], c[0]}, 32'd2, cyc + 2);
        a_req(32'h0000_0400);
        check("t4_stall_at_issue", {127'b0, a_stall}, 128'd1);
        step(1);
        check("t4_stall_after_pop", {127'b0, a_stall}, 128'd0);
        drain("t4a", 4);
        expect_a({64'b0, c[3], c[2]}, 32'd4, cyc + 2);
        a_req(32'h0000_0408);
        drain("t4b", 6);
        // FIFO now empty: a mode-1 request must wait, then flush cancels it
        a_mode = 1'b1;
        a_req(32'h0000_0410);
        step(5);
        a_flush = 1'b1;
        step(1);
        a_flush = 1'b0;
        check("t4_flush_accept", {127'b0, a_accept}, 128'd1);

        // 5: flush in the same cycle the issue condition appears keeps both entries
        a_reset("t5_rst");
        a_mode = 1'b0;
        a_push(IA);
        a_req(32'h0000_0500);
        a_push(IB);
        a_flush = 1'b1;
        step(1);
        a_flush = 1'b0;
        check("t5_accept_after_flush", {127'b0, a_accept}, 128'd1);
        check("t5_no_stall", {127'b0, a_stall}, 128'd0);
        step(3);
        expect_a({64'b0, IB, IA}, 32'd2, cyc + 2);
        a_req(32'h0000_0504);
        drain("t5a", 6);
        // Flush together with rd in IDLE drops the request
        a_mode = 1'b1;
        a_push(32'hcafe0001);
        a_pc = 32'h0000_0600; a_rd = 1'b1; a_flush = 1'b1;
        step(1);
        a_rd = 1'b0; a_flush = 1'b0;
        check("t5_idle_flush_accept", {127'b0, a_accept}, 128'd1);
        check("t5_idle_flush_pc", {96'b0, a_pend_pc}, 128'h504);
        step(3);
        expect_a({64'b0, NOP, 32'hcafe0001}, 32'd3, cyc + 2);
        a_req(32'h0000_0604);
        drain("t5b", 6);
        // Invalidate cancels a pending request as well
        a_req(32'h0000_0700);
        a_inval = 1'b1;
        step(1);
        a_inval = 1'b0;
        check("t5_inval_accept", {127'b0, a_accept}, 128'd1);

        // 6a: reset while pending with 3 entries discards everything
        a_reset("t6a_rst");
        a_mode = 1'b0;
        a_push(32'hd0000000);
        a_push(32'hd0000001);
        a_push(32'hd0000002);
        a_req(32'h0000_0800);
        a_rst = 1'b1;
        step(1);
        a_rst = 1'b0;
        check("t6a_valid", {127'b0, a_valid}, 128'd0);
        check("t6a_accept", {127'b0, a_accept}, 128'd1);
        check("t6a_issued", {96'b0, a_issued}, 128'd0);
        check("t6a_pend_pc", {96'b0, a_pend_pc}, 128'd0);
        a_mode = 1'b1;
        a_req(32'h0000_0804);
        step(4);
        a_inval = 1'b1;
        step(1);
        a_inval = 1'b0;
        expect_a({64'b0, NOP, 32'he0000000}, 32'd1, -1);
        a_push(32'he0000000);
        a_req(32'h0000_0808);
        drain("t6a", 6);

        // 6b: SLOTS=4, DEPTH=8
        b_reset("t6b_rst");
        b_mode = 1'b0;
        b_push(32'hf0000000);
        b_push(32'hf0000001);
        b_push(32'hf0000002);
        b_req(32'h0000_0900);
        step(2);
        check("t6b_pend_wait", {127'b0, b_accept}, 128'd0);
        b_rst = 1'b1;
        step(1);
        b_rst = 1'b0;
        check("t6b_valid", {127'b0, b_valid}, 128'd0);
        check("t6b_accept", {127'b0, b_accept}, 128'd1);
        check("t6b_issued", {96'b0, b_issued}, 128'd0);
        check("t6b_stall", {127'b0, b_stall}, 128'd0);
        for (int i = 0; i < 4; i++) b_push(32'ha0000000 + 32'(i));
        expect_b({32'ha0000003, 32'ha0000002, 32'ha0000001, 32'ha0000000}, 32'd4, cyc + 2);
        b_req(32'h0000_0a00);
        drain("t6b_full", 6);
        b_mode = 1'b1;
        for (int i = 0; i < 3; i++) b_push(32'hb0000000 + 32'(i));
        expect_b({NOP, 32'hb0000002, 32'hb0000001, 32'hb0000000}, 32'd7, cyc + 2);
        b_req(32'h0000_0b00);
        drain("t6b_pad", 6);

        step(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
